// File: rtl/exp_job_sequencer_pkg.sv
// rtl/exp_job_sequencer_pkg.sv - shared widths, watchdog limit and FSM encoding for exp_job_sequencer
package exp_job_sequencer_pkg;

    localparam int XW_DEFAULT = 16;
    localparam int RW_DEFAULT = 16;

    // WAIT_BUSY cycles with the engine still idle before the start pulse is reissued
    localparam int WD_LIMIT = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_OUT       = 3'd4
    } seq_state_t;

endpackage

// File: rtl/exp_job_sequencer_sync_fifo.sv
// rtl/exp_job_sequencer_sync_fifo.sv - single-clock FIFO with show-ahead head and occupancy count
module sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Storage carries no reset; only the pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/exp_job_sequencer.sv
// rtl/exp_job_sequencer.sv - buffers operands, runs one engine job at a time, streams results in order
module exp_job_sequencer
    import exp_job_sequencer_pkg::*;
#(
    parameter int XW    = XW_DEFAULT,
    parameter int RW    = RW_DEFAULT,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [XW-1:0] in_x,
    output logic          in_ready,
    output logic          eng_start,
    output logic [XW-1:0] eng_x,
    input  logic          eng_ready,
    input  logic [RW-1:0] eng_result,
    output logic          out_valid,
    output logic [RW-1:0] out_result,
    input  logic          out_ready,
    output logic [CW-1:0] fifo_count,
    output logic          busy
);

    localparam int WDW = $clog2(WD_LIMIT);
    localparam logic [WDW-1:0] WD_LAST = WDW'(WD_LIMIT - 1);

    seq_state_t     state;
    logic [WDW-1:0] wd_cnt;
    logic           push;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [XW-1:0]  fifo_head;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign pop      = (state == ST_IDLE) && !fifo_empty && eng_ready;
    assign busy     = (state != ST_IDLE);

    sync_fifo #(
        .W     (XW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (in_x),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // eng_start defaults low every cycle so it can never be held for two cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            wd_cnt     <= '0;
            eng_start  <= 1'b0;
            eng_x      <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
        end else begin
            eng_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        eng_x     <= fifo_head;
                        eng_start <= 1'b1;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    wd_cnt <= '0;
                    state  <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (!eng_ready) begin
                        state <= ST_WAIT_DONE;
                    end else if (wd_cnt == WD_LAST) begin
                        eng_start <= 1'b1;
                        state     <= ST_START;
                    end else begin
                        wd_cnt <= wd_cnt + WDW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (eng_ready) begin
                        out_result <= eng_result;
                        out_valid  <= 1'b1;
                        state      <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exp_job_sequencer.sv
// tb/tb_exp_job_sequencer.sv - directed and randomized checks of exp_job_sequencer against a behavioural engine
module tb_exp_job_sequencer;

    localparam int XW    = 16;
    localparam int RW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [XW-1:0] in_x = '0;
    logic          in_ready;
    logic          eng_start;
    logic [XW-1:0] eng_x;
    logic          eng_ready = 1'b1;
    logic [RW-1:0] eng_result = '0;
    logic          out_valid;
    logic [RW-1:0] out_result;
    wire logic     out_ready;
    logic [CW-1:0] fifo_count;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    exp_job_sequencer #(.XW(XW), .RW(RW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_x       (in_x),
        .in_ready   (in_ready),
        .eng_start  (eng_start),
        .eng_x      (eng_x),
        .eng_ready  (eng_ready),
        .eng_result (eng_result),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine function: x=0x0100 gives r=0x02B8
    function automatic logic [RW-1:0] ref_r(input logic [XW-1:0] x);
        return RW'((x << 1) + 16'h00B8);
    endfunction

    // Consumer ready: directed level or random per cycle
    logic rdy_rand = 1'b0, rdy_dir = 1'b0, rdy_rnd_bit = 1'b0;
    always @(posedge clk) begin
        #1;
        rdy_rnd_bit = ($urandom_range(0, 3) != 0);
    end
    assign out_ready = rdy_rand ? rdy_rnd_bit : rdy_dir;

    // Behavioural engine: idle high, drops on start, returns after a latency with r=f(x)
    int            lat_fix = 0;
    int            ign_req = 0;
    int            ign_done = 0;
    int            ecnt = 0;
    int            xhold_viol = 0;
    logic [XW-1:0] xcap = '0;
    always @(negedge clk) begin
        if (rst) begin
            eng_ready = 1'b1;
            ecnt      = 0;
        end else if (eng_start) begin
            if (ign_req != ign_done) begin
                ign_done++;
            end else if (eng_ready) begin
                eng_ready  = 1'b0;
                xcap       = eng_x;
                eng_result = RW'($urandom);
                ecnt       = (lat_fix > 0) ? lat_fix : int'($urandom_range(2, 6));
            end
        end else if (!eng_ready) begin
            if (eng_x !== xcap) xhold_viol++;
            if (ecnt <= 1) begin
                eng_ready  = 1'b1;
                eng_result = ref_r(xcap);
            end else begin
                ecnt--;
            end
        end
    end

    // Passive observers; all judgement happens in the main sequence
    logic          prev_start = 1'b0, prev_vld = 1'b0, prev_rdy = 1'b0;
    logic [RW-1:0] prev_res = '0;
    int            pulse_viol = 0;
    int            stab_viol = 0;
    int            start_cyc[$];
    logic [RW-1:0] got_q[$];
    always @(negedge clk) begin
        if (rst) begin
            prev_start = 1'b0;
            prev_vld   = 1'b0;
        end else begin
            if (eng_start) begin
                if (prev_start) pulse_viol++;
                start_cyc.push_back(cyc);
            end
            if (prev_vld && !prev_rdy && (!out_valid || out_result !== prev_res)) stab_viol++;
            if (out_valid && out_ready) got_q.push_back(out_result);
            prev_start = eng_start;
            prev_vld   = out_valid;
            prev_rdy   = out_ready;
            prev_res   = out_result;
        end
    end

    logic [RW-1:0] exp_q[$];
    int            sb_idx = 0;
    logic [XW-1:0] xs [5];
    int            s0;
    int            g0;
    int            n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; leaves in_valid high for back-to-back use
    task automatic push_x(input logic [XW-1:0] x);
        int k = 0;
        in_valid = 1'b1;
        in_x     = x;
        while (!in_ready && k < 200) begin
            tick();
            k++;
        end
        chk("push_accept", 32'(in_ready), 1);
        exp_q.push_back(ref_r(x));
        tick();
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        @(negedge clk);
        while ((busy || fifo_count != 0 || out_valid) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(k < 3000), 1);
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!out_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(k < 200), 1);
    endtask

    task automatic accept_one();
        wait_valid("accept_wait");
        tick();
        rdy_dir = 1'b1;
        tick();
        rdy_dir = 1'b0;
    endtask

    task automatic check_sb(input string tag);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = sb_idx; i < got_q.size() && i < exp_q.size(); i++) begin
            chk(tag, 32'(got_q[i]), 32'(exp_q[i]));
        end
        sb_idx = got_q.size();
    endtask

    initial begin
        // Reset values
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_eng_start", 32'(eng_start), 0);
        chk("rst_eng_x", 32'(eng_x), 0);
        chk("rst_out_result", 32'(out_result), 0);

        // Single job: start pulse two cycles after the push, one cycle wide
        tick();
        lat_fix = 3;
        rdy_dir = 1'b0;
        push_x(16'h0100);
        in_valid = 1'b0;
        @(negedge clk);
        chk("sj_start_early", 32'(eng_start), 0);
        @(negedge clk);
        chk("sj_start_pulse", 32'(eng_start), 1);
        chk("sj_eng_x", 32'(eng_x), 32'h0100);
        chk("sj_busy", 32'(busy), 1);
        @(negedge clk);
        chk("sj_start_width", 32'(eng_start), 0);
        wait_valid("sj_wait_valid");
        chk("sj_result", 32'(out_result), 32'h02B8);
        chk("sj_eng_x_hold", 32'(eng_x), 32'h0100);
        tick();
        rdy_dir = 1'b1;
        wait_idle("sj_drain");
        check_sb("sj_sb");
        chk("sj_starts", 32'(start_cyc.size()), 1);

        // Burst of five with the consumer stalled, then a push during a pop at count 2
        tick();
        rdy_dir = 1'b0;
        lat_fix = 0;
        s0 = start_cyc.size();
        for (int i = 0; i < 5; i++) begin
            xs[i] = XW'($urandom);
            push_x(xs[i]);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("burst_full_in_ready", 32'(in_ready), 0);
        chk("burst_full_count", 32'(fifo_count), 4);
        wait_valid("burst_wait_valid");
        repeat (10) @(negedge clk);
        chk("bp_out_valid", 32'(out_valid), 1);
        chk("bp_out_result", 32'(out_result), 32'(exp_q[sb_idx]));
        chk("bp_no_new_start", 32'(start_cyc.size()), 32'(s0 + 1));
        chk("bp_count_kept", 32'(fifo_count), 4);
        accept_one();
        accept_one();
        accept_one();
        in_valid = 1'b1;
        in_x     = 16'hC0DE;
        @(negedge clk);
        chk("pp_count_before", 32'(fifo_count), 2);
        tick();
        in_valid = 1'b0;
        exp_q.push_back(ref_r(16'hC0DE));
        @(negedge clk);
        chk("pp_count_after", 32'(fifo_count), 2);
        chk("pp_start", 32'(eng_start), 1);
        chk("pp_older_popped", 32'(eng_x), 32'(xs[3]));
        tick();
        rdy_dir = 1'b1;
        wait_idle("burst_drain");
        check_sb("burst_sb");
        chk("burst_starts", 32'(start_cyc.size() - s0), 6);

        // Watchdog: engine ignores the first start
        tick();
        lat_fix = 3;
        ign_req++;
        s0 = start_cyc.size();
        push_x(16'h1234);
        in_valid = 1'b0;
        wait_idle("wd_drain");
        chk("wd_starts", 32'(start_cyc.size() - s0), 2);
        if (start_cyc.size() >= s0 + 2) begin
            chk("wd_restart_gap", 32'(start_cyc[s0 + 1] - start_cyc[s0]), 5);
        end
        check_sb("wd_sb");

        // Reset while the engine is mid-job with two operands queued
        tick();
        lat_fix = 20;
        rdy_dir = 1'b1;
        for (int i = 0; i < 3; i++) push_x(XW'($urandom));
        in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!(busy && !eng_ready && !eng_start) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rj_reach_wait", 32'(n < 100), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("rj_queued", 32'(fifo_count), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rj_busy", 32'(busy), 0);
        chk("rj_count", 32'(fifo_count), 0);
        chk("rj_out_valid", 32'(out_valid), 0);
        chk("rj_eng_start", 32'(eng_start), 0);
        while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
        g0 = got_q.size();
        s0 = start_cyc.size();
        repeat (40) @(negedge clk);
        chk("rj_no_stale_out", 32'(got_q.size()), 32'(g0));
        chk("rj_no_start", 32'(start_cyc.size()), 32'(s0));

        // Randomized traffic against the in-order model
        tick();
        lat_fix  = 0;
        rdy_rand = 1'b1;
        s0 = start_cyc.size();
        for (int i = 0; i < 20; i++) begin
            n = $urandom_range(0, 3);
            if (n > 0) begin
                in_valid = 1'b0;
                repeat (n) tick();
            end
            push_x(XW'($urandom));
        end
        in_valid = 1'b0;
        wait_idle("rnd_drain");
        rdy_rand = 1'b0;
        check_sb("rnd_sb");
        chk("rnd_starts", 32'(start_cyc.size() - s0), 20);

        chk("start_pulse_width", 32'(pulse_viol), 0);
        chk("eng_x_held", 32'(xhold_viol), 0);
        chk("out_stable", 32'(stab_viol), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
